prog_loader: RTL and testbench

//  Serial boot loader upstream of the CPU's instruction memory. Accepts a byte stream (from a

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_word_packer.sv | 45 ++++
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial boot loader: frame constants, FSM encoding
// and the byte-lane insert helper used by the word packer.
package prog_loader_pkg;

    localparam int unsigned LDR_ADDR_W = 8;
    localparam logic [7:0]  LDR_MAGIC  = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LEN0 = 3'd1,
        LDR_LEN1 = 3'd2,
        LDR_DATA = 3'd3,
        LDR_CSUM = 3'd4,
        LDR_RUN  = 3'd5,
        LDR_ERR  = 3'd6
    } ldr_state_e;

    // Little-endian placement: byte index 0 lands in bits [7:0].
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[8*idx +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/prog_loader_word_packer.sv
// Assembles four consecutive payload bytes into one little-endian 32-bit word
// and flags the byte that completes it.
module prog_loader_word_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_ready,
    output logic [31:0] word_next
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    // word_next already contains the byte being accepted, so the top can
    // register the finished word on the same edge as the 4th byte.
    assign word_next  = insert_byte(word_q, idx_q, byte_in);
    assign word_ready = shift_en && (idx_q == 2'd3);

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (start) begin
            idx_d  = '0;
            word_d = '0;
        end else if (shift_en) begin
            idx_d  = idx_q + 2'd1;
            word_d = word_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses MAGIC/LEN/payload/CSUM frames from a byte stream, writes
// the payload words into imem and holds the CPU in reset until a valid image lands.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = LDR_ADDR_W,
    parameter logic [7:0]  MAGIC  = LDR_MAGIC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] LEN_MAX = 17'(1) << ADDR_W;

    ldr_state_e        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        csum_q, csum_d;
    logic              rx_ready_q, imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   addr_inc;
    logic              pk_start, pk_shift, word_ready;
    logic [31:0]       word_next;

    assign accept   = rx_valid && rx_ready_q;
    assign len_full = {rx_data, len_lo_q};
    // One extra bit so a full-capacity image (len == 2**ADDR_W) is still detected.
    assign addr_inc = {1'b0, addr_q} + (ADDR_W+1)'(1);

    prog_loader_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .start      (pk_start),
        .shift_en   (pk_shift),
        .byte_in    (rx_data),
        .word_ready (word_ready),
        .word_next  (word_next)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        addr_d       = addr_q;
        csum_d       = csum_q;
        pk_start     = 1'b0;
        pk_shift     = 1'b0;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;

        if (accept) begin
            unique case (state_q)
                LDR_IDLE: if (rx_data == MAGIC) state_d = LDR_LEN0;
                LDR_LEN0: begin
                    len_lo_d = rx_data;
                    state_d  = LDR_LEN1;
                end
                LDR_LEN1: begin
                    len_d    = len_full[ADDR_W:0];
                    addr_d   = '0;
                    csum_d   = '0;
                    pk_start = 1'b1;
                    if ({1'b0, len_full} > LEN_MAX) state_d = LDR_ERR;
                    else if (len_full == 16'd0)     state_d = LDR_CSUM;
                    else                            state_d = LDR_DATA;
                end
                LDR_DATA: begin
                    pk_shift = 1'b1;
                    csum_d   = csum_q ^ rx_data;
                    if (word_ready) begin
                        imem_we_d    = 1'b1;
                        imem_waddr_d = addr_q;
                        imem_wdata_d = word_next;
                        addr_d       = addr_inc[ADDR_W-1:0];
                        if (addr_inc == len_q) state_d = LDR_CSUM;
                    end
                end
                LDR_CSUM: state_d = (rx_data == csum_q) ? LDR_RUN : LDR_ERR;
                LDR_RUN,
                LDR_ERR:  if (rx_data == MAGIC) state_d = LDR_LEN0;
                default:  state_d = LDR_IDLE;
            endcase
        end

        // Status outputs are registered from the next state so they track it with no extra lag.
        cpu_reset_d = (state_d != LDR_RUN);
        load_done_d = (state_d == LDR_RUN);
        load_err_d  = (state_d == LDR_ERR);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q      <= LDR_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            csum_q       <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            csum_q       <= csum_d;
            rx_ready_q   <= 1'b1;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are driven byte by byte and every imem
// write is logged into a shadow image compared against hand-built expectations.
module tb_prog_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    logic [31:0] tb_mem [256];
    int          hits   [256];
    logic [31:0] snap   [256];
    logic [7:0]  frame_q [$];

    // Write log, sampled on the falling edge while imem_we is stable.
    always @(negedge clk) begin
        if (imem_we) begin
            tb_mem[imem_waddr] = imem_wdata;
            hits[imem_waddr]   = hits[imem_waddr] + 1;
            wr_cnt             = wr_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int k, input int seed);
        return 8'((k * 7 + seed) & 255);
    endfunction

    function automatic logic [31:0] exp_word(input int a, input int seed);
        return {pay(4*a+3, seed), pay(4*a+2, seed), pay(4*a+1, seed), pay(4*a, seed)};
    endfunction

    task automatic build_frame(input int len, input int seed, input logic [7:0] csum_flip);
        logic [7:0] cs;
        logic [15:0] l16;
        cs  = 8'h00;
        l16 = 16'(len);
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(l16[7:0]);
        frame_q.push_back(l16[15:8]);
        for (int k = 0; k < 4*len; k++) begin
            frame_q.push_back(pay(k, seed));
            cs = cs ^ pay(k, seed);
        end
        frame_q.push_back(cs ^ csum_flip);
    endtask

    // Called on a falling edge; returns on the next falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            send_byte(frame_q[i]);
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            hits[i]   = 0;
            tb_mem[i] = 32'h0;
        end
    endtask

    task automatic check_image(input string tag, input int len, input int seed);
        int bad;
        bad = 0;
        for (int a = 0; a < len; a++)
            if (tb_mem[a] !== exp_word(a, seed) || hits[a] != 1) bad++;
        check({tag, "_bad_words"}, 32'(bad), 32'd0);
        check({tag, "_we_count"}, 32'(wr_cnt), 32'(len));
    endtask

    initial begin
        int diff;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clear_log();
        idle(3);

        // Reset state
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_rx_ready",  32'(rx_ready),  32'd0);
        check("rst_imem_we",   32'(imem_we),   32'd0);
        check("rst_waddr",     32'(imem_waddr), 32'd0);
        check("rst_wdata",     imem_wdata,     32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err",  32'(load_err),  32'd0);
        reset = 1'b0;
        idle(1);
        check("ready_after_rst", 32'(rx_ready), 32'd1);

        // 1: two-word frame; XOR of 11..88 is 88
        clear_log();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_range(0, 11, 1'b0);
        check("t1_pre_csum_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(frame_q[11]);
        check("t1_cpu_reset_fall", 32'(cpu_reset), 32'd0);
        check("t1_load_done",      32'(load_done), 32'd1);
        check("t1_load_err",       32'(load_err),  32'd0);
        idle(2);
        check("t1_word0", tb_mem[0], 32'h44332211);
        check("t1_word1", tb_mem[1], 32'h88776655);
        check("t1_we_count", 32'(wr_cnt), 32'd2);

        // 2: bad checksum, then recovery with a gapped valid frame
        frame_q[11] = 8'h89;
        send_range(0, 12, 1'b0);
        check("t2_load_err",   32'(load_err),  32'd1);
        check("t2_cpu_reset",  32'(cpu_reset), 32'd1);
        check("t2_load_done",  32'(load_done), 32'd0);
        clear_log();
        build_frame(3, 5, 8'h00);
        send_range(0, frame_q.size(), 1'b1);
        check("t2_recover_done", 32'(load_done), 32'd1);
        check("t2_recover_err",  32'(load_err),  32'd0);
        idle(2);
        check_image("t2", 3, 5);

        // 5b: MAGIC while running reasserts cpu_reset on the next cycle
        send_byte(8'hA5);
        check("t5_run_magic_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t5_run_magic_done",      32'(load_done), 32'd0);

        // 3: zero-length frame, then zero-length with bad checksum
        clear_log();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("t3_len0_done", 32'(load_done), 32'd1);
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h07};
        send_range(0, 4, 1'b0);
        check("t3_bad_len0_err",   32'(load_err),  32'd1);
        check("t3_bad_len0_reset", 32'(cpu_reset), 32'd1);
        idle(2);
        check("t3_no_writes", 32'(wr_cnt), 32'd0);

        // 4: len=257 rejected after LEN_hi; len=256 fills imem exactly
        frame_q = '{8'hA5, 8'h01, 8'h01};
        send_range(0, 2, 1'b0);
        check("t4_err_cleared_by_magic", 32'(load_err), 32'd0);
        send_byte(frame_q[2]);
        check("t4_len257_err", 32'(load_err), 32'd1);
        idle(2);
        check("t4_len257_no_writes", 32'(wr_cnt), 32'd0);
        build_frame(256, 3, 8'h00);
        send_range(0, frame_q.size(), 1'b0);
        check("t4_len256_done", 32'(load_done), 32'd1);
        idle(2);
        check_image("t4_len256", 256, 3);

        // 5: reset after two payload words
        clear_log();
        build_frame(4, 9, 8'h00);
        send_range(0, 11, 1'b0);
        idle(1);
        check("t5_two_words", 32'(wr_cnt), 32'd2);
        reset = 1'b1;
        idle(2);
        check("t5_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t5_rst_imem_we",   32'(imem_we),   32'd0);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h12 + i));
        idle(2);
        check("t5_no_more_writes", 32'(wr_cnt), 32'd2);
        check("t5_partial_word1",  tb_mem[1], exp_word(1, 9));
        check("t5_idle_done",      32'(load_done), 32'd0);
        check("t5_idle_err",       32'(load_err),  32'd0);

        // 6: streamed vs gapped delivery of the same frame
        clear_log();
        build_frame(5, 8'h40, 8'h00);
        send_range(0, frame_q.size(), 1'b0);
        idle(2);
        check_image("t6_stream", 5, 8'h40);
        for (int i = 0; i < 256; i++) snap[i] = tb_mem[i];
        clear_log();
        send_range(0, frame_q.size(), 1'b1);
        idle(2);
        check_image("t6_gapped", 5, 8'h40);
        check("t6_gapped_done", 32'(load_done), 32'd1);
        diff = 0;
        for (int i = 0; i < 5; i++) if (snap[i] !== tb_mem[i]) diff++;
        check("t6_images_equal", 32'(diff), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
